// File: rtl/can_pkg.sv
// Shared field codes and field lengths for the CAN receive-side frame sequencer.
package can_pkg;

   localparam int CNT_W = 7;

   typedef enum logic [3:0] {
      F_IDLE    = 4'd0,
      F_IFS     = 4'd1,
      F_ARB_ID  = 4'd2,
      F_SRR_RTR = 4'd3,
      F_IDE     = 4'd4,
      F_ID_EXT  = 4'd5,
      F_RTR_EXT = 4'd6,
      F_RES     = 4'd7,
      F_DLC     = 4'd8,
      F_DATA    = 4'd9,
      F_CRC     = 4'd10,
      F_CRC_DEL = 4'd11,
      F_ACK     = 4'd12,
      F_ACK_DEL = 4'd13,
      F_EOF     = 4'd14,
      F_ERROR   = 4'd15
   } field_t;

   localparam logic [CNT_W-1:0] LEN_ARB_ID   = 7'd11;
   localparam logic [CNT_W-1:0] LEN_ID_EXT   = 7'd18;
   localparam logic [CNT_W-1:0] LEN_DLC      = 7'd4;
   localparam logic [CNT_W-1:0] LEN_CRC      = 7'd15;
   localparam logic [CNT_W-1:0] LEN_EOF      = 7'd7;
   localparam logic [CNT_W-1:0] LEN_IFS      = 7'd3;
   localparam logic [CNT_W-1:0] LEN_ERR_IDLE = 7'd11;
   localparam logic [CNT_W-1:0] LEN_ONE      = 7'd1;
   localparam logic [CNT_W-1:0] LEN_RES_EXT  = 7'd2;

   // DLC values above 8 still carry only eight data bytes.
   function automatic logic [CNT_W-1:0] dataBits(input logic [3:0] dlcVal);
      logic [3:0] clipped;
      clipped = (dlcVal > 4'd8) ? 4'd8 : dlcVal;
      return {clipped, 3'b000};
   endfunction

   function automatic logic isStuffedField(input field_t f);
      return (f >= F_ARB_ID) && (f <= F_CRC);
   endfunction

endpackage

// File: rtl/can_field_cnt.sv
// Down-counter holding the remaining bits of the current frame field.
module can_field_cnt
   import can_pkg::*;
(
   input  logic             i_clock,
   input  logic             i_resetN,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_loadVal,
   input  logic             i_dec,
   output logic             o_last
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_last = (r_count == 7'd1);

endmodule

// File: rtl/can_stuff_ctrl.sv
// CAN receive frame sequencer: tracks the current field, destuffs data bits,
// gates the stuff checker and flags stuff/form errors.
module can_stuff_ctrl
   import can_pkg::*;
(
   input  logic       clock,
   input  logic       resetN,
   input  logic       samplePoint,
   input  logic       canRX,
   input  logic       stuffing,
   input  logic       bsError,
   output logic       bsOnOff,
   output logic [3:0] rxField,
   output logic       dataBit,
   output logic       dataBitValid,
   output logic [3:0] dlc,
   output logic       ide,
   output logic       rtr,
   output logic       ackSeen,
   output logic       frameDone,
   output logic       formError,
   output logic       stuffError
);

   field_t     r_field;
   logic [3:0] r_dlc;
   logic       r_ide;
   logic       r_rtr;
   logic       r_ackSeen;
   logic       r_dataBit;
   logic       r_dataBitValid;
   logic       r_frameDone;
   logic       r_formError;
   logic       r_stuffError;

   field_t           w_nextField;
   logic             w_bsOnOff;
   logic             w_stuffErr;
   logic             w_stuffHold;
   logic             w_advance;
   logic             w_sof;
   logic             w_valid;
   logic             w_load;
   logic [CNT_W-1:0] w_loadVal;
   logic             w_dec;
   logic             w_last;
   logic             w_formErr;
   logic             w_done;
   logic [3:0]       w_dlcNext;

   assign w_bsOnOff = isStuffedField(r_field) || ((r_field == F_IDLE) && !canRX);
   assign w_stuffErr = samplePoint && bsError && w_bsOnOff;
   // A stuff flag only means something while the stuff checker is enabled.
   assign w_stuffHold = stuffing && w_bsOnOff;
   assign w_advance = samplePoint && !w_stuffErr && !w_stuffHold;
   assign w_sof = w_advance && !canRX && ((r_field == F_IDLE) || (r_field == F_IFS));
   assign w_valid = w_advance && (isStuffedField(r_field) || w_sof);
   assign w_dlcNext = {r_dlc[2:0], canRX};

   can_field_cnt u_fieldCnt (
      .i_clock   (clock),
      .i_resetN  (resetN),
      .i_load    (w_load),
      .i_loadVal (w_loadVal),
      .i_dec     (w_dec),
      .o_last    (w_last)
   );

   always_comb begin
      w_nextField = r_field;
      w_load      = 1'b0;
      w_loadVal   = '0;
      w_dec       = 1'b0;
      w_formErr   = 1'b0;
      w_done      = 1'b0;
      if (w_stuffErr) begin
         w_nextField = F_ERROR;
         w_load      = 1'b1;
         w_loadVal   = LEN_ERR_IDLE;
      end else if (w_sof) begin
         w_nextField = F_ARB_ID;
         w_load      = 1'b1;
         w_loadVal   = LEN_ARB_ID;
      end else if (w_advance) begin
         w_dec = 1'b1;
         case (r_field)
            F_IDLE: w_dec = 1'b0;
            F_IFS: if (w_last) begin
               w_nextField = F_IDLE;
               w_load      = 1'b1;
            end
            F_ARB_ID: if (w_last) begin
               w_nextField = F_SRR_RTR;
               w_load      = 1'b1;
               w_loadVal   = LEN_ONE;
            end
            F_SRR_RTR: begin
               w_nextField = F_IDE;
               w_load      = 1'b1;
               w_loadVal   = LEN_ONE;
            end
            F_IDE: begin
               w_nextField = canRX ? F_ID_EXT : F_RES;
               w_load      = 1'b1;
               w_loadVal   = canRX ? LEN_ID_EXT : LEN_ONE;
            end
            F_ID_EXT: if (w_last) begin
               w_nextField = F_RTR_EXT;
               w_load      = 1'b1;
               w_loadVal   = LEN_ONE;
            end
            F_RTR_EXT: begin
               w_nextField = F_RES;
               w_load      = 1'b1;
               w_loadVal   = LEN_RES_EXT;
            end
            F_RES: if (w_last) begin
               w_nextField = F_DLC;
               w_load      = 1'b1;
               w_loadVal   = LEN_DLC;
            end
            F_DLC: if (w_last) begin
               w_load = 1'b1;
               if (r_rtr || (w_dlcNext == 4'd0)) begin
                  w_nextField = F_CRC;
                  w_loadVal   = LEN_CRC;
               end else begin
                  w_nextField = F_DATA;
                  w_loadVal   = dataBits(w_dlcNext);
               end
            end
            F_DATA: if (w_last) begin
               w_nextField = F_CRC;
               w_load      = 1'b1;
               w_loadVal   = LEN_CRC;
            end
            F_CRC: if (w_last) begin
               w_nextField = F_CRC_DEL;
               w_load      = 1'b1;
               w_loadVal   = LEN_ONE;
            end
            F_CRC_DEL, F_ACK_DEL: begin
               w_load = 1'b1;
               if (!canRX) begin
                  w_formErr   = 1'b1;
                  w_nextField = F_ERROR;
                  w_loadVal   = LEN_ERR_IDLE;
               end else begin
                  w_nextField = (r_field == F_CRC_DEL) ? F_ACK : F_EOF;
                  w_loadVal   = (r_field == F_CRC_DEL) ? LEN_ONE : LEN_EOF;
               end
            end
            F_ACK: begin
               w_nextField = F_ACK_DEL;
               w_load      = 1'b1;
               w_loadVal   = LEN_ONE;
            end
            F_EOF: if (!canRX) begin
               w_formErr   = 1'b1;
               w_nextField = F_ERROR;
               w_load      = 1'b1;
               w_loadVal   = LEN_ERR_IDLE;
            end else if (w_last) begin
               w_done      = 1'b1;
               w_nextField = F_IFS;
               w_load      = 1'b1;
               w_loadVal   = LEN_IFS;
            end
            // Any dominant sample restarts the recovery run of recessive bits.
            F_ERROR: if (!canRX) begin
               w_load    = 1'b1;
               w_loadVal = LEN_ERR_IDLE;
            end else if (w_last) begin
               w_nextField = F_IDLE;
               w_load      = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_field        <= F_IDLE;
         r_dlc          <= 4'd0;
         r_ide          <= 1'b0;
         r_rtr          <= 1'b0;
         r_ackSeen      <= 1'b0;
         r_dataBit      <= 1'b0;
         r_dataBitValid <= 1'b0;
         r_frameDone    <= 1'b0;
         r_formError    <= 1'b0;
         r_stuffError   <= 1'b0;
      end else begin
         r_field        <= w_nextField;
         r_dataBitValid <= w_valid;
         r_frameDone    <= w_done;
         r_formError    <= w_formErr;
         r_stuffError   <= w_stuffErr;
         if (w_valid) begin
            r_dataBit <= canRX;
         end
         if (w_sof) begin
            r_ackSeen <= 1'b0;
         end else if (w_advance && (r_field == F_ACK) && !canRX) begin
            r_ackSeen <= 1'b1;
         end
         if (w_advance) begin
            case (r_field)
               F_SRR_RTR, F_RTR_EXT: r_rtr <= canRX;
               F_IDE:                r_ide <= canRX;
               F_DLC:                r_dlc <= w_dlcNext;
               default: ;
            endcase
         end
      end
   end

   assign bsOnOff      = w_bsOnOff;
   assign rxField      = r_field;
   assign dataBit      = r_dataBit;
   assign dataBitValid = r_dataBitValid;
   assign dlc          = r_dlc;
   assign ide          = r_ide;
   assign rtr          = r_rtr;
   assign ackSeen      = r_ackSeen;
   assign frameDone    = r_frameDone;
   assign formError    = r_formError;
   assign stuffError   = r_stuffError;

endmodule

// File: tb/tb_can_stuff_ctrl.sv
// Self-checking bench for can_stuff_ctrl: frames are laid out bit by bit from
// the CAN field rules and every sample's expected response is derived from that layout.
module tb_can_stuff_ctrl;

   localparam logic [3:0] FD_IDLE = 4'd0, FD_IFS = 4'd1, FD_ARB = 4'd2, FD_SRR = 4'd3;
   localparam logic [3:0] FD_IDE = 4'd4, FD_IDEXT = 4'd5, FD_RTREXT = 4'd6, FD_RES = 4'd7;
   localparam logic [3:0] FD_DLC = 4'd8, FD_DATA = 4'd9, FD_CRC = 4'd10, FD_CRCDEL = 4'd11;
   localparam logic [3:0] FD_ACK = 4'd12, FD_ACKDEL = 4'd13, FD_EOF = 4'd14, FD_ERR = 4'd15;

   logic       clock = 1'b0;
   logic       resetN;
   logic       samplePoint;
   logic       canRX;
   logic       stuffing;
   logic       bsError;
   logic       bsOnOff;
   logic [3:0] rxField;
   logic       dataBit;
   logic       dataBitValid;
   logic [3:0] dlc;
   logic       ide;
   logic       rtr;
   logic       ackSeen;
   logic       frameDone;
   logic       formError;
   logic       stuffError;

   int total = 0;
   int bad = 0;
   int doneCount = 0;

   typedef struct {
      logic       rx;
      logic [3:0] fld;
   } pbit_t;

   typedef struct {
      logic        ide;
      logic [28:0] id;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
      logic [14:0] crc;
      logic        ack;
      int          formErr;
      int          nIfs;
      logic [3:0]  startFld;
   } fr_t;

   typedef struct {
      logic       sp, rx, st, be;
      logic       expOn;
      logic [3:0] expFld;
      logic       expValid, expSe;
   } vec_t;

   pbit_t plan[$];

   can_stuff_ctrl dut (
      .clock        (clock),
      .resetN       (resetN),
      .samplePoint  (samplePoint),
      .canRX        (canRX),
      .stuffing     (stuffing),
      .bsError      (bsError),
      .bsOnOff      (bsOnOff),
      .rxField      (rxField),
      .dataBit      (dataBit),
      .dataBitValid (dataBitValid),
      .dlc          (dlc),
      .ide          (ide),
      .rtr          (rtr),
      .ackSeen      (ackSeen),
      .frameDone    (frameDone),
      .formError    (formError),
      .stuffError   (stuffError)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (frameDone === 1'b1) doneCount++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input logic [3:0] expFld, input logic expValid, input logic expBit,
                              input logic expDone, input logic expForm, input logic expSe);
      check("rxField", 32'(rxField), 32'(expFld));
      check("dataBitValid", 32'(dataBitValid), 32'(expValid));
      if (expValid) check("dataBit", 32'(dataBit), 32'(expBit));
      check("frameDone", 32'(frameDone), 32'(expDone));
      check("formError", 32'(formError), 32'(expForm));
      check("stuffError", 32'(stuffError), 32'(expSe));
   endtask

   task automatic checkReset(input string tag);
      $display("[TB] reset value check: %s", tag);
      check("rst_rxField", 32'(rxField), 32'(FD_IDLE));
      check("rst_dlc", 32'(dlc), 32'd0);
      check("rst_ide", 32'(ide), 32'd0);
      check("rst_rtr", 32'(rtr), 32'd0);
      check("rst_ackSeen", 32'(ackSeen), 32'd0);
      check("rst_dataBit", 32'(dataBit), 32'd0);
      check("rst_dataBitValid", 32'(dataBitValid), 32'd0);
      check("rst_frameDone", 32'(frameDone), 32'd0);
      check("rst_formError", 32'(formError), 32'd0);
      check("rst_stuffError", 32'(stuffError), 32'd0);
      check("rst_bsOnOff", 32'(bsOnOff), 32'd0);
   endtask

   // One sample-point cycle; bsOnOff is checked before the edge, the rest after it.
   task automatic applyStimulus(input logic rx, input logic st, input logic be,
                                input logic expOn, input logic [3:0] expFld, input logic expValid,
                                input logic expDone, input logic expForm, input logic expSe);
      @(negedge clock);
      canRX = rx; stuffing = st; bsError = be; samplePoint = 1'b1;
      #1;
      check("bsOnOff", 32'(bsOnOff), 32'(expOn));
      @(posedge clock);
      #1;
      samplePoint = 1'b0; stuffing = 1'b0; bsError = 1'b0;
      checkOutput(expFld, expValid, rx, expDone, expForm, expSe);
   endtask

   // Non-sample cycles with noise on the other inputs must not disturb anything.
   task automatic gap(input logic [3:0] curFld);
      int n;
      n = $urandom_range(2);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         samplePoint = 1'b0;
         canRX = 1'($urandom_range(1));
         stuffing = 1'($urandom_range(1));
         bsError = 1'($urandom_range(1));
         @(posedge clock);
         #1;
         checkOutput(curFld, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      stuffing = 1'b0; bsError = 1'b0;
   endtask

   task automatic addBits(input logic [63:0] v, input int n, input logic [3:0] fld);
      for (int k = n - 1; k >= 0; k--) plan.push_back('{rx: v[k], fld: fld});
   endtask

   function automatic int firstIdx(input logic [3:0] fld);
      for (int k = 0; k < plan.size(); k++) if (plan[k].fld == fld) return k;
      return -1;
   endfunction

   function automatic int lastIdx(input logic [3:0] fld);
      int r;
      r = -1;
      for (int k = 0; k < plan.size(); k++) if (plan[k].fld == fld) r = k;
      return r;
   endfunction

   task automatic buildFrame(input fr_t f);
      int nd;
      plan.delete();
      addBits(64'd0, 1, f.startFld);
      if (!f.ide) begin
         addBits(64'(f.id[10:0]), 11, FD_ARB);
         addBits(64'(f.rtr), 1, FD_SRR);
         addBits(64'd0, 1, FD_IDE);
         addBits(64'd0, 1, FD_RES);
      end else begin
         addBits(64'(f.id[28:18]), 11, FD_ARB);
         addBits(64'd1, 1, FD_SRR);
         addBits(64'd1, 1, FD_IDE);
         addBits(64'(f.id[17:0]), 18, FD_IDEXT);
         addBits(64'(f.rtr), 1, FD_RTREXT);
         addBits(64'd0, 2, FD_RES);
      end
      addBits(64'(f.dlc), 4, FD_DLC);
      nd = f.rtr ? 0 : 8 * ((f.dlc > 4'd8) ? 8 : int'(f.dlc));
      if (nd > 0) addBits(f.data >> (64 - nd), nd, FD_DATA);
      addBits(64'(f.crc), 15, FD_CRC);
      addBits((f.formErr == 1) ? 64'd0 : 64'd1, 1, FD_CRCDEL);
      addBits(f.ack ? 64'd0 : 64'd1, 1, FD_ACK);
      addBits((f.formErr == 2) ? 64'd0 : 64'd1, 1, FD_ACKDEL);
      addBits(64'h7F, 7, FD_EOF);
      if (f.formErr == 3) plan[plan.size() - 1 - $urandom_range(6)].rx = 1'b0;
      addBits(64'hFFFF_FFFF_FFFF_FFFF, f.nIfs, FD_IFS);
   endtask

   // outcome: 0 frame completed, 1 ended in ERROR, 2 stopped early at stopIdx
   task automatic runPlan(input int stopIdx, input int errIdx, input int stuffAt, input int stuffPct,
                          input logic [3:0] finalFld, output int outcome);
      pbit_t cur;
      logic [3:0] nxt;
      logic isStuffed, expOn, expValid, expForm, expDone, be;
      outcome = 0;
      for (int i = 0; i < plan.size(); i++) begin
         if (i == stopIdx) begin
            outcome = 2;
            return;
         end
         cur = plan[i];
         isStuffed = (cur.fld >= FD_ARB) && (cur.fld <= FD_CRC);
         if (isStuffed && ((i == stuffAt) || ($urandom_range(99) < 32'(stuffPct)))) begin
            gap(cur.fld);
            applyStimulus(~plan[i-1].rx, 1'b1, 1'b0, 1'b1, cur.fld, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         gap(cur.fld);
         if (i == errIdx) begin
            applyStimulus(cur.rx, 1'b0, 1'b1, 1'b1, FD_ERR, 1'b0, 1'b0, 1'b0, 1'b1);
            outcome = 1;
            return;
         end
         nxt = (i + 1 < plan.size()) ? plan[i+1].fld : finalFld;
         expOn = isStuffed || ((cur.fld == FD_IDLE) && !cur.rx);
         expValid = isStuffed || (((cur.fld == FD_IDLE) || (cur.fld == FD_IFS)) && !cur.rx);
         expForm = ((cur.fld == FD_CRCDEL) || (cur.fld == FD_ACKDEL) || (cur.fld == FD_EOF)) && !cur.rx;
         if (expForm) nxt = FD_ERR;
         expDone = !expForm && (cur.fld == FD_EOF) && (nxt != FD_EOF);
         be = expOn ? 1'b0 : 1'($urandom_range(1));
         applyStimulus(cur.rx, 1'b0, be, expOn, nxt, expValid, expDone, expForm, 1'b0);
         if (expForm) begin
            outcome = 1;
            return;
         end
      end
   endtask

   // Leave ERROR: field returns to IDLE on the 11th recessive sample in a row.
   task automatic recover(input int randomMode);
      int run, n;
      logic rx;
      run = 0;
      n = 0;
      while (run < 11) begin
         if (n >= 400) begin
            check("recoverBound", 32'(rxField), 32'(FD_IDLE));
            return;
         end
         if (randomMode != 0) rx = ($urandom_range(99) < 10) ? 1'b0 : 1'b1;
         else rx = (n == 5) ? 1'b0 : 1'b1;
         run = rx ? run + 1 : 0;
         applyStimulus(rx, 1'b0, 1'($urandom_range(1)), 1'b0, (run == 11) ? FD_IDLE : FD_ERR,
                       1'b0, 1'b0, 1'b0, 1'b0);
         n++;
      end
   endtask

   task automatic endChecks(input fr_t f);
      check("dlc", 32'(dlc), 32'(f.dlc));
      check("ide", 32'(ide), 32'(f.ide));
      check("rtr", 32'(rtr), 32'(f.rtr));
      check("ackSeen", 32'(ackSeen), 32'(f.ack));
   endtask

   function automatic fr_t stdFrame(input logic [10:0] id, input logic [3:0] d, input logic [63:0] data);
      fr_t f;
      f.ide = 1'b0; f.id = 29'(id); f.rtr = 1'b0; f.dlc = d; f.data = data;
      f.crc = 15'h2B4C; f.ack = 1'b1; f.formErr = 0; f.nIfs = 3; f.startFld = FD_IDLE;
      return f;
   endfunction

   initial begin
      vec_t tbl[8];
      fr_t f;
      int oc, d0, idx;
      logic [3:0] nextStart;

      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FD_IDLE, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FD_IDLE, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FD_IDLE, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, FD_IDLE, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, FD_IDLE, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FD_ARB, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, FD_ARB, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, FD_ERR, 1'b0, 1'b1};

      resetN = 1'b0; samplePoint = 1'b0; canRX = 1'b1; stuffing = 1'b0; bsError = 1'b0;
      #12;
      checkReset("power-on");
      @(negedge clock);
      resetN = 1'b1;

      $display("[TB] idle / SOF vector table");
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         samplePoint = tbl[i].sp; canRX = tbl[i].rx; stuffing = tbl[i].st; bsError = tbl[i].be;
         #1;
         check("tbl_bsOnOff", 32'(bsOnOff), 32'(tbl[i].expOn));
         @(posedge clock);
         #1;
         samplePoint = 1'b0; stuffing = 1'b0; bsError = 1'b0;
         check("tbl_rxField", 32'(rxField), 32'(tbl[i].expFld));
         check("tbl_dataBitValid", 32'(dataBitValid), 32'(tbl[i].expValid));
         check("tbl_stuffError", 32'(stuffError), 32'(tbl[i].expSe));
      end
      recover(0);

      $display("[TB] std data frame ID 0x123 DLC 1 data 0xA5");
      f = stdFrame(11'h123, 4'd1, 64'hA5 << 56);
      buildFrame(f);
      d0 = doneCount;
      runPlan(-1, -1, -1, 0, FD_IDLE, oc);
      check("outcome33", 32'(oc), 32'd0);
      endChecks(f);
      @(posedge clock); #1;
      check("frameDoneCount33", 32'(doneCount - d0), 32'd1);

      $display("[TB] stuff bit after five dominant bits");
      f = stdFrame(11'h07F, 4'd0, 64'd0);
      buildFrame(f);
      runPlan(-1, -1, 5, 0, FD_IDLE, oc);
      check("outcome34", 32'(oc), 32'd0);
      endChecks(f);

      $display("[TB] stuff error in DATA");
      f = stdFrame(11'h2C5, 4'd2, 64'h3C96 << 48);
      buildFrame(f);
      runPlan(-1, firstIdx(FD_DATA) + 3, -1, 0, FD_IDLE, oc);
      check("outcome35", 32'(oc), 32'd1);
      recover(0);

      $display("[TB] dominant CRC delimiter");
      f = stdFrame(11'h555, 4'd3, {$urandom, $urandom});
      f.formErr = 1;
      buildFrame(f);
      d0 = doneCount;
      runPlan(-1, -1, -1, 0, FD_IDLE, oc);
      check("outcome36", 32'(oc), 32'd1);
      @(posedge clock); #1;
      check("frameDoneCount36", 32'(doneCount - d0), 32'd0);
      recover(1);

      $display("[TB] remote frame DLC 4, extended frame DLC 12");
      f = stdFrame(11'h1A0, 4'd4, 64'd0);
      f.rtr = 1'b1; f.ack = 1'b0;
      buildFrame(f);
      runPlan(-1, -1, -1, 0, FD_IDLE, oc);
      endChecks(f);
      f = stdFrame(11'h000, 4'd12, {$urandom, $urandom});
      f.ide = 1'b1; f.id = 29'h1ABCDEF5;
      buildFrame(f);
      runPlan(-1, -1, -1, 10, FD_IDLE, oc);
      endChecks(f);

      $display("[TB] reset in the middle of DATA");
      f = stdFrame(11'h000, 4'd8, 64'hFFEE_DDCC_BBAA_9988);
      f.ide = 1'b1; f.id = 29'h0F0F0F0F;
      buildFrame(f);
      runPlan(firstIdx(FD_DATA) + 10, -1, -1, 0, FD_IDLE, oc);
      check("outcome38", 32'(oc), 32'd2);
      canRX = 1'b1;
      #2;
      resetN = 1'b0;
      #1;
      checkReset("mid-frame");
      @(negedge clock);
      @(negedge clock);
      resetN = 1'b1;
      f = stdFrame(11'h321, 4'd5, {$urandom, $urandom});
      buildFrame(f);
      runPlan(-1, -1, -1, 0, FD_IDLE, oc);
      check("outcome38b", 32'(oc), 32'd0);
      endChecks(f);

      $display("[TB] randomized frames");
      nextStart = FD_IDLE;
      for (int t = 0; t < 40; t++) begin
         f.ide = 1'($urandom_range(1));
         f.id = 29'($urandom);
         f.rtr = ($urandom_range(99) < 20) ? 1'b1 : 1'b0;
         f.dlc = 4'($urandom_range(15));
         f.data = {$urandom, $urandom};
         f.crc = 15'($urandom);
         f.ack = ($urandom_range(99) < 75) ? 1'b1 : 1'b0;
         f.formErr = ($urandom_range(99) < 10) ? int'($urandom_range(1, 3)) : 0;
         f.nIfs = (t == 39) ? 3 : int'($urandom_range(3));
         f.startFld = nextStart;
         buildFrame(f);
         idx = ($urandom_range(99) < 10) ? int'($urandom_range(1, lastIdx(FD_CRC))) : -1;
         runPlan(-1, idx, -1, 15, (f.nIfs == 3) ? FD_IDLE : FD_IFS, oc);
         if (oc == 0) begin
            endChecks(f);
            nextStart = (f.nIfs == 3) ? FD_IDLE : FD_IFS;
         end else begin
            recover(1);
            nextStart = FD_IDLE;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
